// File: rtl/wait_state_memory.sv
// Byte-addressable load/store memory with programmable wait states.
// Ports: clk, rst_n; memory_read/memory_write request strobes; option
// (funct3 size/sign); address (byte, wraps to MEMORY_SIZE); write_data
// (right-aligned); read_data (formatted load); memory_response (one-cycle
// completion); misaligned_error (with response); busy (access in flight).
module wait_state_memory #(
   parameter int MEMORY_SIZE = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        memory_read,
   input  logic        memory_write,
   input  logic [2:0]  option,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        memory_response,
   output logic        misaligned_error,
   output logic        busy
);

   localparam int AW    = $clog2(MEMORY_SIZE);
   localparam int DEPTH = MEMORY_SIZE / 4;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state, state_nx;
   logic [3:0]  cnt, cnt_nx;
   logic        enter_resp;
   logic        req;

   logic [AW-1:0] addr_q;
   logic [2:0]    opt_q;
   logic [31:0]   wdata_q;
   logic          wr_q;

   logic [31:0] mem [DEPTH];

   logic          unused_addr;
   assign unused_addr = ^address[31:AW];

   assign req  = memory_read | memory_write;
   assign busy = (state != IDLE);

   // WAIT is always entered and holds for WAIT_STATES+1 cycles, so the
   // response lands in the cycle after edge E0+WAIT_STATES+1.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      enter_resp = 1'b0;
      unique case (state)
         IDLE: begin
            if (req) begin
               state_nx = WAIT;
               cnt_nx   = 4'(WAIT_STATES);
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               state_nx   = RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Write wins when both strobes are high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         opt_q   <= 3'b0;
         wdata_q <= 32'b0;
         wr_q    <= 1'b0;
      end else if (state == IDLE && req) begin
         addr_q  <= address[AW-1:0];
         opt_q   <= option;
         wdata_q <= write_data;
         wr_q    <= memory_write;
      end
   end

   logic [1:0]    lane;
   logic [AW-3:0] widx;
   logic          is_byte, is_half, is_word, sx, mis;
   logic [31:0]   rd_word, sh, load_val, wd;
   logic [3:0]    be;

   assign lane    = addr_q[1:0];
   assign widx    = addr_q[AW-1:2];
   assign is_byte = (opt_q[1:0] == 2'b00);
   assign is_half = (opt_q[1:0] == 2'b01);
   assign is_word = opt_q[1];
   assign sx      = ~opt_q[2];
   assign mis     = (is_half & lane[0]) | (is_word & (lane != 2'b00));
   assign rd_word = mem[widx];
   assign sh      = rd_word >> {lane, 3'b000};

   // Byte/half data is replicated across lanes; be picks the live ones.
   always_comb begin
      load_val = sh;
      be       = 4'hf;
      wd       = wdata_q;
      unique case (1'b1)
         is_byte: begin
            load_val = {{24{sx & sh[7]}}, sh[7:0]};
            be       = 4'b0001 << lane;
            wd       = {4{wdata_q[7:0]}};
         end
         is_half: begin
            load_val = {{16{sx & sh[15]}}, sh[15:0]};
            be       = 4'b0011 << {lane[1], 1'b0};
            wd       = {2{wdata_q[15:0]}};
         end
         default: ;
      endcase
   end

   // Reset forces IDLE asynchronously, so no commit can follow a reset.
   always_ff @(posedge clk) begin
      if (enter_resp && wr_q && !mis) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[widx][i*8 +: 8] <= wd[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         read_data        <= 32'b0;
         memory_response  <= 1'b0;
         misaligned_error <= 1'b0;
      end else begin
         memory_response  <= enter_resp;
         misaligned_error <= enter_resp & mis;
         if (enter_resp && !wr_q) begin
            read_data <= mis ? 32'b0 : load_val;
         end
      end
   end

endmodule

// File: tb/tb_wait_state_memory.sv
// Randomised bench for wait_state_memory against a byte-array model.
// Checks response/busy timing, load formatting, misalignment and reset.
module tb_wait_state_memory;

   localparam int MS = 1024;
   localparam int AW = 10;
   localparam int WS = 2;

   logic        clk, rst_n, memory_read, memory_write;
   logic [2:0]  option;
   logic [31:0] address, write_data, read_data;
   logic        memory_response, misaligned_error, busy;

   wait_state_memory #(.MEMORY_SIZE(MS), .WAIT_STATES(WS)) dut (
      .clk(clk), .rst_n(rst_n),
      .memory_read(memory_read), .memory_write(memory_write),
      .option(option), .address(address), .write_data(write_data),
      .read_data(read_data), .memory_response(memory_response),
      .misaligned_error(misaligned_error), .busy(busy)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int resp_at = -1;
   int busy_from = 1 << 30;
   logic [31:0] exp_rd_now = 0;
   logic [31:0] exp_rd_pend = 0;
   bit exp_err_pend = 0;
   bit pend_load = 0;
   logic [7:0] mem_m [MS];

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t",
                  name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cyc == resp_at && pend_load) exp_rd_now = exp_rd_pend;
      chk("resp", {31'b0, memory_response}, {31'b0, cyc == resp_at});
      chk("busy", {31'b0, busy},
          {31'b0, (cyc >= busy_from) && (cyc <= resp_at)});
      chk("err", {31'b0, misaligned_error},
          {31'b0, (cyc == resp_at) && exp_err_pend});
      chk("rdata", read_data, exp_rd_now);
   end

   task automatic decode(input logic [2:0] opt, input logic [31:0] addr,
                         output int a, output int sz, output bit mis,
                         output bit uns);
      a = int'(addr[AW-1:0]);
      case (opt)
         3'd0, 3'd4: sz = 1;
         3'd1, 3'd5: sz = 2;
         default:    sz = 4;
      endcase
      uns = (opt == 3'd4) || (opt == 3'd5);
      mis = (sz == 2 && (a % 2) != 0) || (sz == 4 && (a % 4) != 0);
   endtask

   task automatic predict(input logic [2:0] opt, input logic [31:0] addr,
                          output logic [31:0] v, output bit mis);
      int a, sz;
      bit uns;
      decode(opt, addr, a, sz, mis, uns);
      v = 0;
      if (!mis) begin
         for (int b = 0; b < sz; b++) v = v | (32'(mem_m[a + b]) << (8 * b));
         if (!uns && sz < 4 && v[8 * sz - 1])
            v = v | (32'hFFFFFFFF << (8 * sz));
      end
   endtask

   task automatic commit(input logic [2:0] opt, input logic [31:0] addr,
                         input logic [31:0] wd);
      int a, sz;
      bit mis, uns;
      logic [31:0] d;
      decode(opt, addr, a, sz, mis, uns);
      d = wd;
      if (!mis)
         for (int b = 0; b < sz; b++) mem_m[a + b] = d[8 * b +: 8];
   endtask

   task automatic access(input bit rd, input bit wr, input logic [2:0] opt,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] got, output bit got_err,
                         output int lat);
      logic [31:0] e;
      bit m, seen;
      int k;
      predict(opt, addr, e, m);
      k = cyc + 1;
      exp_rd_pend  = e;
      exp_err_pend = m;
      pend_load    = !wr;
      busy_from    = k;
      resp_at      = k + WS + 1;
      memory_read  = rd;
      memory_write = wr;
      option       = opt;
      address      = addr;
      write_data   = wd;
      seen = 0;
      lat = -1;
      got = 'x;
      got_err = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (memory_response) begin
            seen = 1;
            got = read_data;
            got_err = misaligned_error;
            lat = cyc - k;
         end
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL timeout actual=no_response required=response");
         resp_at = -1;
      end
      if (seen && wr) commit(opt, addr, wd);
      @(posedge clk);
      #2;
      memory_read  = 0;
      memory_write = 0;
   endtask

   logic [31:0] g, pv, pre;
   bit ge, pm;
   int l;

   initial begin
      rst_n = 1;
      memory_read = 0;
      memory_write = 0;
      option = 0;
      address = 0;
      write_data = 0;
      #1 rst_n = 0;
      #1;
      chk("rst0_busy", {31'b0, busy}, 0);
      chk("rst0_resp", {31'b0, memory_response}, 0);
      chk("rst0_err", {31'b0, misaligned_error}, 0);
      chk("rst0_rdata", read_data, 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1;
      @(posedge clk);
      #2;

      for (int w = 0; w < MS / 4; w++)
         access(0, 1, 3'd2, 32'(w * 4), $urandom, g, ge, l);

      access(0, 1, 3'd2, 32'h40, 32'hDEADBEEF, g, ge, l);
      chk("sw_lat", 32'(l), 3);
      access(1, 0, 3'd2, 32'h40, 0, g, ge, l);
      chk("lw40", g, 32'hDEADBEEF);
      chk("lw_lat", 32'(l), 3);
      predict(3'd0, 32'h43, pv, pm);
      chk("model_lb43", pv, 32'hFFFFFFDE);
      access(1, 0, 3'd0, 32'h43, 0, g, ge, l);
      chk("lb43", g, 32'hFFFFFFDE);
      access(1, 0, 3'd4, 32'h43, 0, g, ge, l);
      chk("lbu43", g, 32'h000000DE);
      access(1, 0, 3'd1, 32'h42, 0, g, ge, l);
      chk("lh42", g, 32'hFFFFDEAD);
      access(1, 0, 3'd5, 32'h40, 0, g, ge, l);
      chk("lhu40", g, 32'h0000BEEF);
      access(0, 1, 3'd0, 32'h41, 32'h12345678, g, ge, l);
      predict(3'd2, 32'h40, pv, pm);
      chk("model_sb", pv, 32'hDEAD78EF);
      access(1, 0, 3'd2, 32'h40, 0, g, ge, l);
      chk("sb_lw40", g, 32'hDEAD78EF);
      access(0, 1, 3'd1, 32'h42, 32'h0000CAFE, g, ge, l);
      access(1, 0, 3'd2, 32'h40, 0, g, ge, l);
      chk("sh_lw40", g, 32'hCAFE78EF);
      access(1, 0, 3'd2, 32'h41, 0, g, ge, l);
      chk("lw41_err", {31'b0, ge}, 1);
      chk("lw41_rdata", g, 0);
      access(0, 1, 3'd1, 32'h43, 32'h0000FFFF, g, ge, l);
      chk("sh43_err", {31'b0, ge}, 1);
      access(1, 0, 3'd2, 32'h40, 0, g, ge, l);
      chk("sh43_lw40", g, 32'hCAFE78EF);
      access(0, 1, 3'd2, 32'h400, 32'h11223344, g, ge, l);
      access(1, 0, 3'd2, 32'h000, 0, g, ge, l);
      chk("wrap_lw0", g, 32'h11223344);
      access(1, 1, 3'd2, 32'h8, 32'hA5A5A5A5, g, ge, l);
      chk("both_rdata", g, 32'h11223344);
      access(1, 0, 3'd2, 32'h8, 0, g, ge, l);
      chk("both_lw8", g, 32'hA5A5A5A5);

      pre = {mem_m[16'h13], mem_m[16'h12], mem_m[16'h11], mem_m[16'h10]};
      busy_from = cyc + 1;
      resp_at = cyc + WS + 2;
      pend_load = 0;
      exp_err_pend = 0;
      memory_write = 1;
      option = 3'd2;
      address = 32'h10;
      write_data = 32'h55AA55AA;
      @(posedge clk);
      #2;
      rst_n = 0;
      resp_at = -1;
      busy_from = 1 << 30;
      exp_rd_now = 0;
      memory_write = 0;
      #1;
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_resp", {31'b0, memory_response}, 0);
      chk("rst_err", {31'b0, misaligned_error}, 0);
      chk("rst_rdata", read_data, 0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1;
      @(posedge clk);
      #2;
      access(1, 0, 3'd2, 32'h10, 0, g, ge, l);
      chk("rst_lw10", g, pre);

      repeat (300) begin
         int op;
         op = $urandom_range(0, 2);
         access(op != 1, op != 0, 3'($urandom_range(0, 7)), $urandom,
                $urandom, g, ge, l);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #2;
         end
      end

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
